// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: steers the hps_io ROM download stream into the Pleiads core's
// program / FG tile / BG tile / palette PROM stores. It counts and checksums
// the accepted bytes, checks the load length, and holds the core in reset
// until a clean load has finished and a fixed settle period has elapsed.
module rom_load_ctrl #(
    parameter int PROG_SIZE  = 16384,
    parameter int FG_SIZE    = 4096,
    parameter int BG_SIZE    = 4096,
    parameter int PROM_SIZE  = 512,
    parameter int RESET_HOLD = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        user_reset,
    input  logic        dn_download,
    input  logic        dn_wr,
    input  logic [15:0] dn_addr,
    input  logic [7:0]  dn_data,
    output logic [13:0] rom_addr,
    output logic [7:0]  rom_data,
    output logic        prog_we,
    output logic        fg_we,
    output logic        bg_we,
    output logic        prom_we,
    output logic        core_reset,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] byte_count,
    output logic [7:0]  checksum
);

    // Region bases are kept one bit wider than the address so a map that
    // ends exactly at 64 KiB still compares correctly.
    localparam logic [16:0] FG_BASE   = 17'(PROG_SIZE);
    localparam logic [16:0] BG_BASE   = 17'(PROG_SIZE + FG_SIZE);
    localparam logic [16:0] PROM_BASE = 17'(PROG_SIZE + FG_SIZE + BG_SIZE);
    localparam logic [16:0] MAP_END   = 17'(PROG_SIZE + FG_SIZE + BG_SIZE + PROM_SIZE);
    localparam logic [15:0] TOTAL     = 16'(PROG_SIZE + FG_SIZE + BG_SIZE + PROM_SIZE);

    localparam int          HW        = $clog2(RESET_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [15:0]     byte_count_q, byte_count_d;
    logic [7:0]      checksum_q, checksum_d;
    logic            oob_q, oob_d;
    logic [13:0]     rom_addr_q, rom_addr_d;
    logic [7:0]      rom_data_q, rom_data_d;
    logic [3:0]      we_q, we_d;          // {prom, bg, fg, prog}
    logic            dl_prev_q;

    logic            dl_rise;
    logic            wr_accept;
    logic [16:0]     addr_ext;

    assign dl_rise   = dn_download & ~dl_prev_q;
    // A strobe in the cycle that starts a download belongs to no load yet.
    assign wr_accept = (state_q == S_LOAD) && dn_wr && !dl_rise;
    assign addr_ext  = {1'b0, dn_addr};

    // Next-state, settle counter and write-path decode.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        byte_count_d = byte_count_q;
        checksum_d   = checksum_q;
        oob_d        = oob_q;
        rom_addr_d   = rom_addr_q;
        rom_data_d   = rom_data_q;
        we_d         = 4'b0000;

        case (state_q)
            S_IDLE: begin
                state_d = S_IDLE;
            end
            S_LOAD: begin
                if (!dn_download) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((byte_count_q == TOTAL) && !oob_q) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    state_d = S_ERROR;
                end
            end
            S_HOLD: begin
                if (user_reset) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_RUN: begin
                if (user_reset) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (wr_accept) begin
            if (addr_ext < MAP_END) begin
                rom_data_d   = dn_data;
                checksum_d   = checksum_q + dn_data;
                byte_count_d = (byte_count_q != 16'hFFFF) ? byte_count_q + 16'd1
                                                          : byte_count_q;
                if (addr_ext < FG_BASE) begin
                    we_d       = 4'b0001;
                    rom_addr_d = 14'(addr_ext);
                end else if (addr_ext < BG_BASE) begin
                    we_d       = 4'b0010;
                    rom_addr_d = 14'(addr_ext - FG_BASE);
                end else if (addr_ext < PROM_BASE) begin
                    we_d       = 4'b0100;
                    rom_addr_d = 14'(addr_ext - BG_BASE);
                end else begin
                    we_d       = 4'b1000;
                    rom_addr_d = 14'(addr_ext - PROM_BASE);
                end
            end else begin
                oob_d = 1'b1;
            end
        end

        // A new download restarts from any state, including RUN.
        if (dl_rise) begin
            state_d      = S_LOAD;
            byte_count_d = '0;
            checksum_d   = '0;
            oob_d        = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= '0;
            byte_count_q <= '0;
            checksum_q   <= '0;
            oob_q        <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            we_q         <= 4'b0000;
            // Sampling the live level means a download already running when
            // reset ends is not mistaken for a fresh rising edge.
            dl_prev_q    <= dn_download;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            byte_count_q <= byte_count_d;
            checksum_q   <= checksum_d;
            oob_q        <= oob_d;
            rom_addr_q   <= rom_addr_d;
            rom_data_q   <= rom_data_d;
            we_q         <= we_d;
            dl_prev_q    <= dn_download;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_data   = rom_data_q;
    assign prog_we    = we_q[0];
    assign fg_we      = we_q[1];
    assign bg_we      = we_q[2];
    assign prom_we    = we_q[3];
    assign core_reset = (state_q != S_RUN);
    assign load_done  = (state_q == S_RUN);
    assign load_error = (state_q == S_ERROR);
    assign byte_count = byte_count_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Testbench for rom_load_ctrl: a decode table for the region boundaries plus
// hand-written sequences for full, short, out-of-range and interrupted loads.
module tb_rom_load_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        user_reset;
    logic        dn_download;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic        prog_we, fg_we, bg_we, prom_we;
    logic        core_reset, load_done, load_error;
    logic [15:0] byte_count;
    logic [7:0]  checksum;

    logic [3:0]  we_vec;
    assign we_vec = {prom_we, bg_we, fg_we, prog_we};

    int n_vec = 0;
    int n_bad = 0;

    // Tallies from the most recent bulk load.
    int cnt_prog, cnt_fg, cnt_bg, cnt_prom, bad_beats;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        logic [3:0]  exp_we;
        logic [13:0] exp_ra;
    } vec_t;

    vec_t tbl [11];

    rom_load_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .user_reset (user_reset),
        .dn_download(dn_download),
        .dn_wr      (dn_wr),
        .dn_addr    (dn_addr),
        .dn_data    (dn_data),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .prog_we    (prog_we),
        .fg_we      (fg_we),
        .bg_we      (bg_we),
        .prom_we    (prom_we),
        .core_reset (core_reset),
        .load_done  (load_done),
        .load_error (load_error),
        .byte_count (byte_count),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode of the default memory map: {we[3:0], offset[13:0]}.
    function automatic logic [17:0] ref_decode(input logic [15:0] a);
        logic [15:0] off;
        if (a < 16'h4000) return {4'b0001, a[13:0]};
        if (a < 16'h5000) begin off = a - 16'h4000; return {4'b0010, off[13:0]}; end
        if (a < 16'h6000) begin off = a - 16'h5000; return {4'b0100, off[13:0]}; end
        if (a < 16'h6200) begin off = a - 16'h6000; return {4'b1000, off[13:0]}; end
        return 18'h0;
    endfunction

    task automatic start_dl(input logic wr_on_rise);
        dn_download = 1'b1;
        dn_wr       = wr_on_rise;
        dn_addr     = 16'h0000;
        dn_data     = 8'h5A;
        step();
        dn_wr = 1'b0;
    endtask

    task automatic end_dl();
        dn_wr       = 1'b0;
        dn_download = 1'b0;
        step();
    endtask

    // Back-to-back writes of data = addr[7:0]; each beat checked right after
    // the edge that registers it.
    task automatic load_range(input int first, input int n);
        logic [17:0] exp;
        logic [15:0] a;
        cnt_prog = 0; cnt_fg = 0; cnt_bg = 0; cnt_prom = 0; bad_beats = 0;
        for (int i = 0; i < n; i++) begin
            a       = 16'(first + i);
            dn_wr   = 1'b1;
            dn_addr = a;
            dn_data = a[7:0];
            step();
            exp = ref_decode(a);
            if (prog_we) cnt_prog++;
            if (fg_we)   cnt_fg++;
            if (bg_we)   cnt_bg++;
            if (prom_we) cnt_prom++;
            if (we_vec !== exp[17:14]) bad_beats++;
            else if (exp[17:14] != 4'b0 && (rom_addr !== exp[13:0] || rom_data !== a[7:0]))
                bad_beats++;
        end
        dn_wr = 1'b0;
    endtask

    initial begin
        int n;
        int exp_cnt;
        logic [7:0] exp_sum;

        tbl[0]  = '{16'h0000, 8'h11, 4'b0001, 14'h0000};
        tbl[1]  = '{16'h3FFF, 8'h22, 4'b0001, 14'h3FFF};
        tbl[2]  = '{16'h4000, 8'h33, 4'b0010, 14'h0000};
        tbl[3]  = '{16'h4ABC, 8'h44, 4'b0010, 14'h0ABC};
        tbl[4]  = '{16'h5000, 8'h55, 4'b0100, 14'h0000};
        tbl[5]  = '{16'h5FFF, 8'h66, 4'b0100, 14'h0FFF};
        tbl[6]  = '{16'h6000, 8'h77, 4'b1000, 14'h0000};
        tbl[7]  = '{16'h61FF, 8'h88, 4'b1000, 14'h01FF};
        tbl[8]  = '{16'h6200, 8'h99, 4'b0000, 14'h0000};
        tbl[9]  = '{16'hFFFF, 8'hAA, 4'b0000, 14'h0000};
        tbl[10] = '{16'h1234, 8'hBB, 4'b0001, 14'h1234};

        reset = 1'b1; user_reset = 1'b0; dn_download = 1'b0;
        dn_wr = 1'b0; dn_addr = 16'h0; dn_data = 8'h0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Reset state.
        chk("reset we", {28'h0, we_vec}, 32'h0);
        chk("reset rom_addr", {18'h0, rom_addr}, 32'h0);
        chk("reset rom_data", {24'h0, rom_data}, 32'h0);
        chk("reset core_reset", {31'h0, core_reset}, 32'h1);
        chk("reset load_done", {31'h0, load_done}, 32'h0);
        chk("reset load_error", {31'h0, load_error}, 32'h0);
        chk("reset byte_count", {16'h0, byte_count}, 32'h0);
        chk("reset checksum", {24'h0, checksum}, 32'h0);

        // Boundary decode table; the strobe on the rising-edge cycle must be dropped.
        start_dl(1'b1);
        chk("rise-cycle wr we", {28'h0, we_vec}, 32'h0);
        chk("rise-cycle wr count", {16'h0, byte_count}, 32'h0);
        exp_cnt = 0; exp_sum = 8'h00;
        for (int i = 0; i < 11; i++) begin
            dn_wr = 1'b1; dn_addr = tbl[i].addr; dn_data = tbl[i].data;
            step();
            chk($sformatf("tbl[%0d] we", i), {28'h0, we_vec}, {28'h0, tbl[i].exp_we});
            if (tbl[i].exp_we != 4'b0) begin
                exp_cnt++;
                exp_sum = exp_sum + tbl[i].data;
                chk($sformatf("tbl[%0d] rom_addr", i), {18'h0, rom_addr}, {18'h0, tbl[i].exp_ra});
                chk($sformatf("tbl[%0d] rom_data", i), {24'h0, rom_data}, {24'h0, tbl[i].data});
            end
        end
        dn_wr = 1'b0;
        chk("tbl byte_count", {16'h0, byte_count}, 32'(exp_cnt));
        chk("tbl checksum", {24'h0, checksum}, {24'h0, exp_sum});
        end_dl();
        step();
        chk("tbl load_error", {31'h0, load_error}, 32'h1);

        // Reset in the middle of a load, download level still high afterwards.
        start_dl(1'b0);
        load_range(0, 100);
        chk("pre-reset byte_count", {16'h0, byte_count}, 32'd100);
        reset = 1'b1; dn_wr = 1'b1; dn_addr = 16'd100; dn_data = 8'd100;
        step();
        chk("mid-reset we", {28'h0, we_vec}, 32'h0);
        chk("mid-reset byte_count", {16'h0, byte_count}, 32'h0);
        chk("mid-reset checksum", {24'h0, checksum}, 32'h0);
        chk("mid-reset rom_addr", {18'h0, rom_addr}, 32'h0);
        chk("mid-reset rom_data", {24'h0, rom_data}, 32'h0);
        chk("mid-reset core_reset", {31'h0, core_reset}, 32'h1);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            dn_addr = 16'(101 + i); dn_data = 8'(101 + i);
            step();
            if (we_vec != 4'b0) n++;
        end
        chk("no resume after reset", 32'(n), 32'h0);
        chk("no resume byte_count", {16'h0, byte_count}, 32'h0);
        dn_wr = 1'b0; dn_download = 1'b0;
        step();

        // Full valid load to RUN.
        start_dl(1'b0);
        load_range(0, 32'h6200);
        chk("prog_we count", 32'(cnt_prog), 32'd16384);
        chk("fg_we count", 32'(cnt_fg), 32'd4096);
        chk("bg_we count", 32'(cnt_bg), 32'd4096);
        chk("prom_we count", 32'(cnt_prom), 32'd512);
        chk("full load bad beats", 32'(bad_beats), 32'd0);
        chk("full byte_count", {16'h0, byte_count}, 32'h6200);
        chk("full checksum", {24'h0, checksum}, 32'h0);
        end_dl();
        chk("check core_reset", {31'h0, core_reset}, 32'h1);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (core_reset) n++;
            else break;
        end
        chk("hold cycles after load", 32'(n), 32'd16);
        chk("run load_done", {31'h0, load_done}, 32'h1);
        chk("run load_error", {31'h0, load_error}, 32'h0);

        // One-cycle user reset while running.
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        n = core_reset ? 1 : 0;
        for (int i = 0; i < 100 && n > 0; i++) begin
            step();
            if (core_reset) n++;
            else break;
        end
        chk("user_reset hold cycles", 32'(n), 32'd16);
        chk("user_reset back to run", {31'h0, load_done}, 32'h1);

        // New download from RUN, short by 0x100 bytes.
        start_dl(1'b0);
        chk("run->load core_reset", {31'h0, core_reset}, 32'h1);
        chk("run->load load_done", {31'h0, load_done}, 32'h0);
        chk("run->load byte_count", {16'h0, byte_count}, 32'h0);
        load_range(0, 32'h6100);
        end_dl();
        step();
        chk("short byte_count", {16'h0, byte_count}, 32'h6100);
        chk("short load_error", {31'h0, load_error}, 32'h1);
        chk("short core_reset", {31'h0, core_reset}, 32'h1);
        user_reset = 1'b1;
        step();
        user_reset = 1'b0;
        repeat (20) step();
        chk("error ignores user_reset", {30'h0, load_error, core_reset}, 32'h3);

        // Full map plus one byte past the end.
        start_dl(1'b0);
        load_range(0, 32'h6200);
        chk("oob run bad beats", 32'(bad_beats), 32'd0);
        dn_wr = 1'b1; dn_addr = 16'h6200; dn_data = 8'hC3;
        step();
        dn_wr = 1'b0;
        chk("oob we", {28'h0, we_vec}, 32'h0);
        chk("oob byte_count", {16'h0, byte_count}, 32'h6200);
        end_dl();
        step();
        chk("oob load_error", {31'h0, load_error}, 32'h1);
        chk("oob load_done", {31'h0, load_done}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
